// File: rtl/layer_seq.sv
// layer_seq: address/strobe sequencer for one fully connected layer.
// Walks every (neuron, input) pair in neuron-major order, issuing memory
// reads one per cycle, and tags each read so the accumulator strobes and
// the output-buffer write line up with the MAC pipeline latency.
module layer_seq #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 10,
    parameter int MAC_LAT = 2,
    parameter int IA_W    = 10,
    parameter int WA_W    = 13,
    parameter int NA_W    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [IA_W-1:0] in_addr,
    output logic [WA_W-1:0] w_addr,
    output logic [NA_W-1:0] b_addr,
    output logic            issue,
    output logic            acc_sel,
    output logic            acc_en,
    output logic            out_we,
    output logic [NA_W-1:0] out_addr
);

    localparam logic [IA_W-1:0] I_LAST = IA_W'(N_IN - 1);
    localparam logic [NA_W-1:0] N_LAST = NA_W'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IA_W-1:0] i_q, i_d;
    logic [NA_W-1:0] n_q, n_d;
    logic [WA_W-1:0] w_q, w_d;
    logic            issue_q, issue_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Tag pipeline: valid, accumulator bias-select, capture, neuron index.
    logic [MAC_LAT-1:0] pv_q;
    logic [MAC_LAT-1:0] ps_q;
    logic [MAC_LAT-1:0] pe_q;
    logic [NA_W-1:0]    pn_q [MAC_LAT];

    logic            out_we_q;
    logic [NA_W-1:0] out_addr_q;

    logic            tag_v, tag_s, tag_e;
    logic            pipe_empty;

    assign tag_v      = issue_q;
    assign tag_s      = issue_q && (i_q == '0);
    assign tag_e      = issue_q && (i_q == I_LAST);
    assign pipe_empty = ~|pv_q;

    // State, counters and issue-side registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            n_q     <= '0;
            w_q     <= '0;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            n_q     <= n_d;
            w_q     <= w_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; the weight address is a running counter, not n*N_IN+i.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        n_d     = n_q;
        w_d     = w_q;
        issue_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    n_d     = '0;
                    w_d     = '0;
                    issue_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                issue_d = 1'b1;
                if (i_q == I_LAST) begin
                    if (n_q == N_LAST) begin
                        // Last element is on the bus now; stop issuing.
                        state_d = DRAIN;
                        issue_d = 1'b0;
                        i_d     = '0;
                        n_d     = '0;
                        w_d     = '0;
                    end else begin
                        i_d = '0;
                        n_d = n_q + 1'b1;
                        w_d = w_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                    w_d = w_q + 1'b1;
                end
            end
            DRAIN: begin
                // The final write is the only one seen with an empty pipe.
                if (pipe_empty && out_we_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < MAC_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // First stage captures the tag of the element issued this cycle.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        pv_q[gi] <= 1'b0;
                        ps_q[gi] <= 1'b0;
                        pe_q[gi] <= 1'b0;
                        pn_q[gi] <= '0;
                    end else begin
                        pv_q[gi] <= tag_v;
                        ps_q[gi] <= tag_s;
                        pe_q[gi] <= tag_e;
                        pn_q[gi] <= tag_v ? n_q : '0;
                    end
                end
            end else begin : g_body
                // Later stages shift the tag along with the MAC pipeline.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        pv_q[gi] <= 1'b0;
                        ps_q[gi] <= 1'b0;
                        pe_q[gi] <= 1'b0;
                        pn_q[gi] <= '0;
                    end else begin
                        pv_q[gi] <= pv_q[gi-1];
                        ps_q[gi] <= ps_q[gi-1];
                        pe_q[gi] <= pe_q[gi-1];
                        pn_q[gi] <= pn_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Write follows capture by one cycle, when the accumulator result is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
        end else begin
            out_we_q   <= pe_q[MAC_LAT-1];
            out_addr_q <= pe_q[MAC_LAT-1] ? pn_q[MAC_LAT-1] : '0;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign issue    = issue_q;
    assign in_addr  = i_q;
    assign w_addr   = w_q;
    assign b_addr   = n_q;
    assign acc_sel  = ps_q[MAC_LAT-1];
    assign acc_en   = pe_q[MAC_LAT-1];
    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: three configurations (4x3 lat 2, 1x2 lat 1,
// and the 784x10 default) sharing one clock and reset.
module tb_layer_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int cyc, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // ---------------- DUT A: N_IN=4, N_OUT=3, MAC_LAT=2 ----------------
    logic       a_start = 1'b0;
    logic       a_busy, a_done, a_issue, a_sel, a_en, a_we;
    logic [1:0] a_in, a_b, a_oaddr;
    logic [3:0] a_w;

    layer_seq #(.N_IN(4), .N_OUT(3), .MAC_LAT(2), .IA_W(2), .WA_W(4), .NA_W(2)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .in_addr(a_in), .w_addr(a_w), .b_addr(a_b), .issue(a_issue),
        .acc_sel(a_sel), .acc_en(a_en), .out_we(a_we), .out_addr(a_oaddr)
    );

    // ---------------- DUT B: N_IN=1, N_OUT=2, MAC_LAT=1 ----------------
    logic b_start = 1'b0;
    logic b_busy, b_done, b_issue, b_sel, b_en, b_we;
    logic b_in, b_w, b_b, b_oaddr;

    layer_seq #(.N_IN(1), .N_OUT(2), .MAC_LAT(1), .IA_W(1), .WA_W(1), .NA_W(1)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .in_addr(b_in), .w_addr(b_w), .b_addr(b_b), .issue(b_issue),
        .acc_sel(b_sel), .acc_en(b_en), .out_we(b_we), .out_addr(b_oaddr)
    );

    // ---------------- DUT C: defaults 784x10, MAC_LAT=2 ----------------
    logic        c_start = 1'b0;
    logic        c_busy, c_done, c_issue, c_sel, c_en, c_we;
    logic [9:0]  c_in;
    logic [12:0] c_w;
    logic [3:0]  c_b, c_oaddr;

    layer_seq u_c (
        .clk(clk), .reset(reset), .start(c_start), .busy(c_busy), .done(c_done),
        .in_addr(c_in), .w_addr(c_w), .b_addr(c_b), .issue(c_issue),
        .acc_sel(c_sel), .acc_en(c_en), .out_we(c_we), .out_addr(c_oaddr)
    );

    // Accumulator + output buffer model attached to DUT A.
    int         bias [3] = '{5, -3, 0};
    int         outbuf [3];
    int         fb, res, m_sum;
    logic [1:0] iss_h;
    logic [1:0] b_h0, b_h1;

    always_comb m_sum = (a_sel ? bias[b_h1] : fb) + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_h <= '0;
            b_h0  <= '0;
            b_h1  <= '0;
            fb    <= 0;
            res   <= 0;
        end else begin
            iss_h <= {iss_h[0], a_issue};
            b_h0  <= a_b;
            b_h1  <= b_h0;
            if (iss_h[1]) begin
                fb <= m_sum;
                if (a_en) res <= m_sum;
            end
            if (a_we) outbuf[a_oaddr] <= res;
        end
    end

    // Full 4x3 run, cycle by cycle; optional extra starts while busy.
    task automatic run_a(input bit extra);
        int  wr;
        bit  ex_issue, ex_we;
        for (int c = 0; c <= 20; c++) begin
            a_start = (c == 0) || (extra && (c == 5 || c == 15));
            @(negedge clk);
            ex_issue = (c >= 1 && c <= 12);
            ex_we    = (c == 7 || c == 11 || c == 15);
            check_val("a_issue", c, a_issue, ex_issue);
            if (ex_issue) begin
                check_val("a_w_addr", c, a_w, c - 1);
                check_val("a_in_addr", c, a_in, (c - 1) % 4);
                check_val("a_b_addr", c, a_b, (c - 1) / 4);
            end
            check_val("a_acc_sel", c, a_sel, (c == 3 || c == 7 || c == 11));
            check_val("a_acc_en", c, a_en, (c == 6 || c == 10 || c == 14));
            check_val("a_out_we", c, a_we, ex_we);
            if (ex_we) check_val("a_out_addr", c, a_oaddr, (c - 7) / 4);
            check_val("a_busy", c, a_busy, (c >= 1 && c <= 15));
            check_val("a_done", c, a_done, (c == 16));
            if (a_we) wr++;
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        check_val("a_write_count", 20, wr, 3);
    endtask

    initial begin
        int wr, first_wr, done_cyc, issues, last_w;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_issue", 0, a_issue, 0);
        check_val("rst_busy", 0, a_busy, 0);
        check_val("rst_done", 0, a_done, 0);
        check_val("rst_out_we", 0, a_we, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Plain run, then datapath contents.
        run_a(1'b0);
        check_val("acc_out0", 0, outbuf[0], 9);
        check_val("acc_out1", 0, outbuf[1], 1);
        check_val("acc_out2", 0, outbuf[2], 4);

        // Same run with starts while busy; must behave identically.
        run_a(1'b1);

        // N_IN=1 configuration.
        for (int c = 0; c <= 8; c++) begin
            b_start = (c == 0);
            @(negedge clk);
            check_val("b_issue", c, b_issue, (c == 1 || c == 2));
            check_val("b_acc_sel", c, b_sel, (c == 2 || c == 3));
            check_val("b_acc_en", c, b_en, (c == 2 || c == 3));
            check_val("b_out_we", c, b_we, (c == 3 || c == 4));
            if (b_we) check_val("b_out_addr", c, b_oaddr, c - 3);
            check_val("b_done", c, b_done, (c == 5));
            @(posedge clk); #1;
        end

        // Default configuration.
        wr = 0; done_cyc = -1; issues = 0; last_w = -1;
        for (int c = 0; c <= 7850; c++) begin
            c_start = (c == 0);
            @(negedge clk);
            if (c_issue) begin
                issues++;
                last_w = int'(c_w);
            end
            if (c_we) begin
                check_val("c_out_addr", c, c_oaddr, wr);
                wr++;
            end
            if (c_done && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
        end
        check_val("c_issue_count", 7850, issues, 7840);
        check_val("c_last_w_addr", 7850, last_w, 7839);
        check_val("c_done_cycle", 7850, done_cyc, 7844);
        check_val("c_write_count", 7850, wr, 10);

        // Reset mid-run, then a fresh run.
        wr = 0; first_wr = -1; done_cyc = -1;
        for (int c = 0; c <= 30; c++) begin
            a_start = (c == 0) || (c == 10);
            if (c == 8) begin
                check_val("pre_rst_issue", c, a_issue, 1);
                reset = 1'b0;
                #1;
                check_val("mid_rst_issue", c, a_issue, 0);
                check_val("mid_rst_busy", c, a_busy, 0);
                check_val("mid_rst_done", c, a_done, 0);
                check_val("mid_rst_sel", c, a_sel, 0);
                check_val("mid_rst_en", c, a_en, 0);
                check_val("mid_rst_we", c, a_we, 0);
                check_val("mid_rst_w_addr", c, a_w, 0);
                check_val("mid_rst_in_addr", c, a_in, 0);
                check_val("mid_rst_b_addr", c, a_b, 0);
                check_val("mid_rst_out_addr", c, a_oaddr, 0);
            end
            if (c == 9) reset = 1'b1;
            @(negedge clk);
            if (c == 11) begin
                check_val("rerun_issue", c, a_issue, 1);
                check_val("rerun_w_addr", c, a_w, 0);
            end
            if (c >= 9 && a_we) begin
                check_val("rerun_out_addr", c, a_oaddr, wr);
                if (first_wr < 0) first_wr = c;
                wr++;
            end
            if (c >= 9 && a_done && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
        end
        a_start = 1'b0;
        check_val("rerun_first_write", 30, first_wr, 17);
        check_val("rerun_write_count", 30, wr, 3);
        check_val("rerun_done_cycle", 30, done_cyc, 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
